segre_mem_stage: RTL and testbench
==================================

SEGRE_MEM_STAGE -- requirements
Module: segre_mem_stage

Interface
REQ-001 Parameter WORD_SIZE, 32, data word width in bits.
REQ-002 Parameter DCACHE_LANE_SIZE, 128, cache line width in bits (4 words).
REQ-003 Parameter DCACHE_NUM_LINES, 4, data-array lines; DCACHE_INDEX_SIZE = log2(DCACHE_NUM_LINES).
REQ-004 Reset is synchronous and active-high; port clk_i is the single clock.
REQ-005 clk_i  in  1  clock, all state updates on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 addr_i  in  WORD_SIZE  memory address, or ALU result for non-memory ops.
REQ-008 rf_we_i / rf_waddr_i  in  1 / REG_SIZE  register write enable and destination.
REQ-009 addr_index_i  in  DCACHE_INDEX_SIZE  data-array line for the access.
REQ-010 memop_rd_i, memop_wr_i, memop_sign_ext_i  in  1 each  load request, store-buffer flush write, load sign extension.
REQ-011 memop_type_i, memop_type_flush_i  in  memop_data_type_e  load size, flush size (BYTE/HALF/WORD).
REQ-012 sb_hit_i  in  1  load served by store buffer; sb_data_load_i  in  WORD_SIZE  right-aligned, unextended load value.
REQ-013 sb_flush_i  in  1; sb_data_flush_i  in  WORD_SIZE; sb_addr_i  in  ADDR_SIZE  flush data and address.
REQ-014 instr_id_i / instr_id_o  in / out  HF_PTR  instruction tag.
REQ-015 mmu_data_rdy_i  in  1; mmu_data_i  in  DCACHE_LANE_SIZE; mmu_lru_index_i  in  DCACHE_INDEX_SIZE  line fill.
REQ-016 mmu_wb_data_o  out  DCACHE_LANE_SIZE  victim line contents, registered.
REQ-017 rf_we_o / rf_waddr_o / rf_wdata_o / instr_id_o  out  1 / REG_SIZE / WORD_SIZE / HF_PTR  writeback interface.
REQ-018 pipeline_hazard_o  out  1  upstream must hold its outputs this cycle.

Function
REQ-019 Data array: DCACHE_NUM_LINES x DCACHE_LANE_SIZE flops, combinational read, synchronous write.
REQ-020 FSM states MEM_IDLE, MEM_REPLAY.
REQ-021 MEM_IDLE, mmu_data_rdy_i & (memop_rd_i|memop_wr_i): fill executes, memory op suppressed, pipeline_hazard_o=1 (combinational), next MEM_REPLAY, WB outputs bubble (rf_we_o=0).
REQ-022 MEM_REPLAY: pipeline_hazard_o=0 unless another fill arrives with memop pending (then REQ-021 repeats, stay MEM_REPLAY); otherwise execute held op, next MEM_IDLE.
REQ-023 Fill: line mmu_lru_index_i <= mmu_data_i; same edge mmu_wb_data_o <= previous contents of that line.
REQ-024 Flush (memop_wr_i & sb_flush_i, not suppressed): write sb_data_flush_i into line addr_index_i; BYTE at offset sb_addr_i[3:0], HALF at word sb_addr_i[3:2], half sb_addr_i[1], WORD at word sb_addr_i[3:2]; untouched bytes preserved; misaligned low bits ignored.
REQ-025 memop_wr_i without sb_flush_i: no array write.
REQ-026 Load (memop_rd_i, not suppressed): source sb_data_load_i if sb_hit_i, else array line addr_index_i word addr_i[3:2], byte addr_i[1:0] / half addr_i[1]; zero- or sign-extend per memop_sign_ext_i to WORD_SIZE.
REQ-027 Load in same cycle as flush to same bytes: load sees pre-write data.
REQ-028 Non-memory op: rf_wdata_o <= addr_i.
REQ-029 Latency 1 cycle: rf_we_o<=rf_we_i, rf_waddr_o, rf_wdata_o, instr_id_o registered on executing edge.

Reset
REQ-030 rst_i=1 at edge: FSM to MEM_IDLE, data array zeroed, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, instr_id_o=0, mmu_wb_data_o=0; pipeline_hazard_o=0 while rst_i=1.
REQ-031 Reset mid-replay abandons the held op; no array write that cycle.

Verification
REQ-032 Fill line 1 = 0x44444444_33333333_22222222_11111111, then load WORD addr 0x14 index 1 -> rf_wdata_o=0x22222222 next cycle.
REQ-033 Load BYTE signed addr 0x13, byte 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Flush HALF 0xBEEF addr 0x16 index 1 then load WORD 0x14 -> 0xBEEF2222.
REQ-035 Fill + load same cycle -> pipeline_hazard_o=1, rf_we_o=0 next edge; held load completes one cycle later with fill data.
REQ-036 sb_hit_i=1, sb_data_load_i=0x00008001, HALF signed -> 0xFFFF8001, array unchanged.
REQ-037 rst_i asserted during MEM_REPLAY -> all outputs 0, array zero, next op executes from MEM_IDLE.

Source files
------------

// File: rtl/segre_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : segre_mem_stage
// Description : Memory stage of the segre pipeline. Holds a small flop-based
//               data array (DCACHE_NUM_LINES x DCACHE_LANE_SIZE) with a
//               combinational read and a synchronous write. Serves loads
//               from the array or from the store buffer, applies
//               store-buffer flush writes, accepts MMU line fills (returning
//               the victim line), and registers the writeback interface.
//               When a fill lands while a memory op is pending, the op is
//               stalled for one cycle (pipeline_hazard_o) and replayed.
// Ports       :
//   clk_i, rst_i                      clock, synchronous active-high reset
//   addr_i, addr_index_i              access address / ALU result, array line
//   rf_we_i, rf_waddr_i, instr_id_i   writeback controls and tag in
//   memop_rd_i/wr_i/sign_ext_i        load, flush write, load sign extension
//   memop_type_i, memop_type_flush_i  load / flush size (0 BYTE,1 HALF,2 WORD)
//   sb_hit_i, sb_data_load_i          store-buffer load forwarding
//   sb_flush_i, sb_data_flush_i,
//   sb_addr_i                         store-buffer flush data and address
//   mmu_data_rdy_i, mmu_data_i,
//   mmu_lru_index_i                   line fill from the MMU
//   mmu_wb_data_o                     previous contents of the filled line
//   rf_we_o, rf_waddr_o, rf_wdata_o,
//   instr_id_o                        registered writeback interface
//   pipeline_hazard_o                 upstream must hold its outputs
// Revision    : 1.0 - initial release
// ============================================================================
module segre_mem_stage #(
    parameter int WORD_SIZE         = 32,
    parameter int DCACHE_LANE_SIZE  = 128,
    parameter int DCACHE_NUM_LINES  = 4,
    parameter int DCACHE_INDEX_SIZE = $clog2(DCACHE_NUM_LINES),
    parameter int REG_SIZE          = 5,
    parameter int ADDR_SIZE         = 32,
    parameter int HF_PTR            = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [WORD_SIZE-1:0]         addr_i,
    input  logic                         rf_we_i,
    input  logic [REG_SIZE-1:0]          rf_waddr_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] addr_index_i,
    input  logic                         memop_rd_i,
    input  logic                         memop_wr_i,
    input  logic                         memop_sign_ext_i,
    input  logic [1:0]                   memop_type_i,
    input  logic [1:0]                   memop_type_flush_i,
    input  logic                         sb_hit_i,
    input  logic [WORD_SIZE-1:0]         sb_data_load_i,
    input  logic                         sb_flush_i,
    input  logic [WORD_SIZE-1:0]         sb_data_flush_i,
    input  logic [ADDR_SIZE-1:0]         sb_addr_i,
    input  logic [HF_PTR-1:0]            instr_id_i,
    input  logic                         mmu_data_rdy_i,
    input  logic [DCACHE_LANE_SIZE-1:0]  mmu_data_i,
    input  logic [DCACHE_INDEX_SIZE-1:0] mmu_lru_index_i,
    output logic [DCACHE_LANE_SIZE-1:0]  mmu_wb_data_o,
    output logic                         rf_we_o,
    output logic [REG_SIZE-1:0]          rf_waddr_o,
    output logic [WORD_SIZE-1:0]         rf_wdata_o,
    output logic [HF_PTR-1:0]            instr_id_o,
    output logic                         pipeline_hazard_o
);

    localparam int LANE_BYTES = DCACHE_LANE_SIZE / 8;

    localparam logic [1:0] c_BYTE = 2'd0;
    localparam logic [1:0] c_HALF = 2'd1;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_REPLAY = 1'b1
    } mem_state_e;

    mem_state_e                  r_state;
    mem_state_e                  w_state_next;
    logic [DCACHE_LANE_SIZE-1:0] r_array [DCACHE_NUM_LINES];
    logic [DCACHE_LANE_SIZE-1:0] r_wb_data;
    logic                        r_rf_we;
    logic [REG_SIZE-1:0]         r_rf_waddr;
    logic [WORD_SIZE-1:0]        r_rf_wdata;
    logic [HF_PTR-1:0]           r_instr_id;

    logic                        w_suppress;
    logic                        w_hazard;
    logic                        w_flush_wr;
    logic [DCACHE_LANE_SIZE-1:0] w_line;
    logic [WORD_SIZE-1:0]        w_word;
    logic [7:0]                  w_byte;
    logic [15:0]                 w_half;
    logic [WORD_SIZE-1:0]        w_ld_data;
    logic [LANE_BYTES-1:0]       w_flush_be;
    logic [DCACHE_LANE_SIZE-1:0] w_flush_rep;
    logic [DCACHE_LANE_SIZE-1:0] w_flush_line;
    logic                        w_unused;

    // A fill always wins the array write port; a memory op in the same
    // cycle is held upstream and replayed on the next cycle.
    assign w_suppress = mmu_data_rdy_i & (memop_rd_i | memop_wr_i);
    assign w_flush_wr = memop_wr_i & sb_flush_i & ~w_suppress;

    // Only the line offset of the flush address selects bytes.
    assign w_unused = ^sb_addr_i[ADDR_SIZE-1:4];

    always_comb begin
        w_state_next = MEM_IDLE;
        w_hazard     = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (w_suppress) begin
                    w_hazard     = 1'b1;
                    w_state_next = MEM_REPLAY;
                end
            end
            MEM_REPLAY: begin
                // A second fill during replay stalls the held op again.
                if (w_suppress) begin
                    w_hazard     = 1'b1;
                    w_state_next = MEM_REPLAY;
                end
            end
            default: begin
                w_state_next = MEM_IDLE;
            end
        endcase
    end

    assign pipeline_hazard_o = w_hazard & ~rst_i;

    // Load path: array line -> word -> byte/half, or store-buffer value.
    assign w_line = r_array[addr_index_i];
    assign w_word = w_line[{addr_i[3:2], 5'b0} +: WORD_SIZE];

    always_comb begin
        w_byte = w_word[{addr_i[1:0], 3'b0} +: 8];
        w_half = w_word[{addr_i[1], 4'b0} +: 16];
        if (sb_hit_i) begin
            // Store-buffer data arrives already right-aligned.
            w_byte = sb_data_load_i[7:0];
            w_half = sb_data_load_i[15:0];
        end
        case (memop_type_i)
            c_BYTE:  w_ld_data = {{(WORD_SIZE-8){memop_sign_ext_i & w_byte[7]}}, w_byte};
            c_HALF:  w_ld_data = {{(WORD_SIZE-16){memop_sign_ext_i & w_half[15]}}, w_half};
            default: w_ld_data = sb_hit_i ? sb_data_load_i : w_word;
        endcase
    end

    // Flush path: replicate the data across the lane and merge by byte enable.
    always_comb begin
        case (memop_type_flush_i)
            c_BYTE: begin
                w_flush_be  = {{(LANE_BYTES-1){1'b0}}, 1'b1} << sb_addr_i[3:0];
                w_flush_rep = {LANE_BYTES{sb_data_flush_i[7:0]}};
            end
            c_HALF: begin
                w_flush_be  = {{(LANE_BYTES-2){1'b0}}, 2'b11} << {sb_addr_i[3:1], 1'b0};
                w_flush_rep = {(LANE_BYTES/2){sb_data_flush_i[15:0]}};
            end
            default: begin
                w_flush_be  = {{(LANE_BYTES-4){1'b0}}, 4'hF} << {sb_addr_i[3:2], 2'b00};
                w_flush_rep = {(DCACHE_LANE_SIZE/WORD_SIZE){sb_data_flush_i}};
            end
        endcase
        for (int b = 0; b < LANE_BYTES; b++) begin
            w_flush_line[b*8 +: 8] = w_flush_be[b] ? w_flush_rep[b*8 +: 8] : w_line[b*8 +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= MEM_IDLE;
            for (int l = 0; l < DCACHE_NUM_LINES; l++) begin
                r_array[l] <= '0;
            end
            r_wb_data  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_instr_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (mmu_data_rdy_i) begin
                r_array[mmu_lru_index_i] <= mmu_data_i;
                r_wb_data                <= r_array[mmu_lru_index_i];
            end else if (w_flush_wr) begin
                r_array[addr_index_i] <= w_flush_line;
            end
            if (w_suppress) begin
                r_rf_we <= 1'b0;
            end else begin
                r_rf_we    <= rf_we_i;
                r_rf_waddr <= rf_waddr_i;
                r_instr_id <= instr_id_i;
                r_rf_wdata <= memop_rd_i ? w_ld_data : addr_i;
            end
        end
    end

    assign mmu_wb_data_o = r_wb_data;
    assign rf_we_o       = r_rf_we;
    assign rf_waddr_o    = r_rf_waddr;
    assign rf_wdata_o    = r_rf_wdata;
    assign instr_id_o    = r_instr_id;

endmodule
`default_nettype wire

// File: tb/tb_segre_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_mem_stage
// Description : Self-checking bench for segre_mem_stage. A byte-array model
//               of the data array predicts every output; directed table
//               vectors cover the documented scenarios, a hand-written
//               sequence covers reset during replay, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_mem_stage;

    typedef struct {
        logic         rst;
        logic [31:0]  addr;
        logic         rf_we;
        logic [4:0]   waddr;
        logic [1:0]   idx;
        logic         rd;
        logic         wr;
        logic         sx;
        logic [1:0]   ty;
        logic [1:0]   tyf;
        logic         hit;
        logic [31:0]  sbl;
        logic         flush;
        logic [31:0]  sbf;
        logic [31:0]  sba;
        logic [3:0]   id;
        logic         rdy;
        logic [127:0] mdata;
        logic [1:0]   lru;
    } vin_t;

    typedef struct {
        vin_t        in;
        string       name;
        bit          chk_wd;
        logic [31:0] exp_wd;
        bit          exp_hz;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic         rf_we_i;
    logic [4:0]   rf_waddr_i;
    logic [1:0]   addr_index_i;
    logic         memop_rd_i, memop_wr_i, memop_sign_ext_i;
    logic [1:0]   memop_type_i, memop_type_flush_i;
    logic         sb_hit_i;
    logic [31:0]  sb_data_load_i;
    logic         sb_flush_i;
    logic [31:0]  sb_data_flush_i;
    logic [31:0]  sb_addr_i;
    logic [3:0]   instr_id_i;
    logic         mmu_data_rdy_i;
    logic [127:0] mmu_data_i;
    logic [1:0]   mmu_lru_index_i;
    logic [127:0] mmu_wb_data_o;
    logic         rf_we_o;
    logic [4:0]   rf_waddr_o;
    logic [31:0]  rf_wdata_o;
    logic [3:0]   instr_id_o;
    logic         pipeline_hazard_o;

    segre_mem_stage dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .addr_i             (addr_i),
        .rf_we_i            (rf_we_i),
        .rf_waddr_i         (rf_waddr_i),
        .addr_index_i       (addr_index_i),
        .memop_rd_i         (memop_rd_i),
        .memop_wr_i         (memop_wr_i),
        .memop_sign_ext_i   (memop_sign_ext_i),
        .memop_type_i       (memop_type_i),
        .memop_type_flush_i (memop_type_flush_i),
        .sb_hit_i           (sb_hit_i),
        .sb_data_load_i     (sb_data_load_i),
        .sb_flush_i         (sb_flush_i),
        .sb_data_flush_i    (sb_data_flush_i),
        .sb_addr_i          (sb_addr_i),
        .instr_id_i         (instr_id_i),
        .mmu_data_rdy_i     (mmu_data_rdy_i),
        .mmu_data_i         (mmu_data_i),
        .mmu_lru_index_i    (mmu_lru_index_i),
        .mmu_wb_data_o      (mmu_wb_data_o),
        .rf_we_o            (rf_we_o),
        .rf_waddr_o         (rf_waddr_o),
        .rf_wdata_o         (rf_wdata_o),
        .instr_id_o         (instr_id_o),
        .pipeline_hazard_o  (pipeline_hazard_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model state: the array as plain bytes, little-endian per line.
    logic [7:0]   m_mem [4][16];
    logic         m_we    = 1'b0;
    logic [4:0]   m_waddr = '0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_id    = '0;
    logic [127:0] m_wb    = '0;
    logic         last_hz;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    endfunction

    function automatic int offset_of(input logic [3:0] a, input int n);
        // Natural alignment: drop low address bits below the access size.
        return (int'(a) / n) * n;
    endfunction

    // One clock of behaviour; returns the expected combinational hazard.
    task automatic model_step(input vin_t v, output bit hz);
        int          n;
        int          off;
        logic [31:0] val;
        logic [31:0] mask;
        hz = !v.rst && v.rdy && (v.rd || v.wr);
        if (v.rst) begin
            foreach (m_mem[l, k]) m_mem[l][k] = 8'h00;
            m_we = 0; m_waddr = 0; m_wdata = 0; m_id = 0; m_wb = 0;
            return;
        end
        if (v.rdy) begin
            for (int k = 0; k < 16; k++) begin
                m_wb[k*8 +: 8]  = m_mem[v.lru][k];
                m_mem[v.lru][k] = v.mdata[k*8 +: 8];
            end
        end
        if (hz) begin
            m_we = 0;
            return;
        end
        // Load sees the array before any flush of this same cycle.
        val = 0;
        if (v.rd) begin
            n    = size_of(v.ty);
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
            if (v.hit) begin
                val = v.sbl & mask;
            end else begin
                off = offset_of(v.addr[3:0], n);
                for (int k = 0; k < n; k++) val = val | (32'(m_mem[v.idx][off+k]) << (8*k));
            end
            if (v.sx && n < 4 && val[8*n-1]) val = val | ~mask;
        end
        if (v.wr && v.flush) begin
            n   = size_of(v.tyf);
            off = offset_of(v.sba[3:0], n);
            for (int k = 0; k < n; k++) m_mem[v.idx][off+k] = v.sbf[8*k +: 8];
        end
        m_we    = v.rf_we;
        m_waddr = v.waddr;
        m_id    = v.id;
        m_wdata = v.rd ? val : v.addr;
    endtask

    task automatic apply(input vin_t v, input string name);
        bit hz;
        rst_i = v.rst; addr_i = v.addr; rf_we_i = v.rf_we; rf_waddr_i = v.waddr;
        addr_index_i = v.idx; memop_rd_i = v.rd; memop_wr_i = v.wr;
        memop_sign_ext_i = v.sx; memop_type_i = v.ty; memop_type_flush_i = v.tyf;
        sb_hit_i = v.hit; sb_data_load_i = v.sbl; sb_flush_i = v.flush;
        sb_data_flush_i = v.sbf; sb_addr_i = v.sba; instr_id_i = v.id;
        mmu_data_rdy_i = v.rdy; mmu_data_i = v.mdata; mmu_lru_index_i = v.lru;
        #1;
        last_hz = pipeline_hazard_o;
        model_step(v, hz);
        chk({name, ".hazard"}, 128'(last_hz), 128'(hz));
        @(posedge clk_i);
        #1;
        chk({name, ".rf_we"}, 128'(rf_we_o), 128'(m_we));
        chk({name, ".wb"}, mmu_wb_data_o, m_wb);
        if (m_we) begin
            chk({name, ".waddr"}, 128'(rf_waddr_o), 128'(m_waddr));
            chk({name, ".wdata"}, 128'(rf_wdata_o), 128'(m_wdata));
            chk({name, ".id"}, 128'(instr_id_o), 128'(m_id));
        end
    endtask

    function automatic vin_t nop();
        vin_t v;
        v = '{rst: 0, addr: 0, rf_we: 1, waddr: 5'd3, idx: 0, rd: 0, wr: 0, sx: 0,
              ty: 2, tyf: 2, hit: 0, sbl: 0, flush: 0, sbf: 0, sba: 0, id: 4'd1,
              rdy: 0, mdata: 0, lru: 0};
        return v;
    endfunction

    function automatic vin_t ld(input logic [31:0] a, input logic [1:0] idx,
                                input logic [1:0] ty, input logic sx);
        vin_t v = nop();
        v.addr = a; v.idx = idx; v.ty = ty; v.sx = sx; v.rd = 1; v.id = 4'd5;
        return v;
    endfunction

    function automatic vin_t fl(input logic [31:0] a, input logic [1:0] idx,
                                input logic [1:0] ty, input logic [31:0] d);
        vin_t v = nop();
        v.addr = a; v.sba = a; v.idx = idx; v.tyf = ty; v.sbf = d;
        v.wr = 1; v.flush = 1; v.rf_we = 0;
        return v;
    endfunction

    function automatic vin_t fill(input vin_t base, input logic [1:0] lru, input logic [127:0] d);
        vin_t v = base;
        v.rdy = 1; v.lru = lru; v.mdata = d;
        return v;
    endfunction

    localparam logic [127:0] c_LINE1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] c_LINE2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    vec_t tbl[$];

    task automatic add(input vin_t v, input string name, input bit chk_wd,
                       input logic [31:0] exp_wd, input bit exp_hz);
        vec_t e;
        e.in = v; e.name = name; e.chk_wd = chk_wd; e.exp_wd = exp_wd; e.exp_hz = exp_hz;
        tbl.push_back(e);
    endtask

    initial begin
        vin_t v;
        vin_t held;

        // ---------------- directed table ----------------
        v = nop(); v.rst = 1;
        add(v, "reset", 1, 32'h0, 0);
        v = nop(); v.addr = 32'h1234;
        add(fill(v, 2'd1, c_LINE1), "fill_nomem", 1, 32'h1234, 0);
        add(ld(32'h14, 1, 2, 0), "ld_word_14", 1, 32'h22222222, 0);
        add(fl(32'h13, 1, 0, 32'h0000_0080), "fl_byte_13", 1, 32'h13, 0);
        add(ld(32'h13, 1, 0, 1), "ld_byte_s", 1, 32'hFFFFFF80, 0);
        add(ld(32'h13, 1, 0, 0), "ld_byte_u", 1, 32'h00000080, 0);
        add(ld(32'h10, 1, 2, 0), "ld_word_10", 1, 32'h80111111, 0);
        add(fl(32'h16, 1, 1, 32'hDEAD_BEEF), "fl_half_16", 1, 32'h16, 0);
        add(ld(32'h14, 1, 2, 0), "ld_word_beef", 1, 32'hBEEF2222, 0);
        add(ld(32'h16, 1, 1, 1), "ld_half_s", 1, 32'hFFFFBEEF, 0);
        add(ld(32'h17, 1, 1, 0), "ld_half_mis", 1, 32'h0000BEEF, 0);
        v = ld(32'h14, 1, 1, 1); v.hit = 1; v.sbl = 32'h0000_8001;
        add(v, "sb_hit_half", 1, 32'hFFFF8001, 0);
        add(ld(32'h14, 1, 2, 0), "ld_after_hit", 1, 32'hBEEF2222, 0);
        v = fl(32'h18, 1, 2, 32'hCAFE_F00D); v.rd = 1; v.ty = 2; v.rf_we = 1;
        add(v, "ld_fl_same", 1, 32'h33333333, 0);
        add(ld(32'h1B, 1, 2, 0), "ld_word_mis", 1, 32'hCAFEF00D, 0);
        v = fl(32'h18, 1, 2, 32'h1111_2222); v.flush = 0;
        add(v, "wr_noflush", 0, 32'h0, 0);
        add(ld(32'h18, 1, 2, 0), "ld_unchanged", 1, 32'hCAFEF00D, 0);
        add(fill(ld(32'h24, 2, 2, 0), 2'd2, c_LINE2), "fill_ld", 0, 32'h0, 1);
        add(ld(32'h24, 2, 2, 0), "replay_ld", 1, 32'hBBBBBBBB, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].in, tbl[i].name);
            chk({tbl[i].name, ".tbl_hz"}, 128'(last_hz), 128'(tbl[i].exp_hz));
            if (tbl[i].chk_wd)
                chk({tbl[i].name, ".tbl_wdata"}, 128'(rf_wdata_o), 128'(tbl[i].exp_wd));
            if (tbl[i].exp_hz)
                chk({tbl[i].name, ".tbl_bubble"}, 128'(rf_we_o), 128'(0));
        end

        // ---------------- reset during replay ----------------
        held = fill(ld(32'h1C, 1, 2, 0), 2'd3, c_LINE1);
        apply(held, "rr_stall");
        chk("rr_stall.hz", 128'(last_hz), 128'(1));
        held.rst = 1;
        apply(held, "rr_reset");
        chk("rr_reset.hz", 128'(last_hz), 128'(0));
        chk("rr_reset.we", 128'(rf_we_o), 128'(0));
        chk("rr_reset.wdata", 128'(rf_wdata_o), 128'(0));
        chk("rr_reset.wb", mmu_wb_data_o, 128'(0));
        for (int l = 0; l < 4; l++) begin
            for (int w = 0; w < 4; w++) begin
                apply(ld(32'(w*4), 2'(l), 2, 0), "rr_zero");
                chk("rr_zero.wdata", 128'(rf_wdata_o), 128'(0));
            end
        end
        v = nop(); v.addr = 32'h5A5A;
        apply(v, "rr_next");
        chk("rr_next.wdata", 128'(rf_wdata_o), 128'h5A5A);
        chk("rr_next.we", 128'(rf_we_o), 128'(1));

        // ---------------- random traffic ----------------
        for (int c = 0; c < 600; c++) begin
            v.rst   = ($urandom_range(0, 60) == 0);
            v.addr  = $urandom;
            v.rf_we = 1'($urandom);
            v.waddr = 5'($urandom);
            v.idx   = 2'($urandom);
            v.rd    = ($urandom_range(0, 2) != 0);
            v.wr    = ($urandom_range(0, 2) == 0);
            v.sx    = 1'($urandom);
            v.ty    = 2'($urandom_range(0, 2));
            v.tyf   = 2'($urandom_range(0, 2));
            v.hit   = ($urandom_range(0, 4) == 0);
            v.sbl   = $urandom;
            v.flush = 1'($urandom);
            v.sbf   = $urandom;
            v.sba   = $urandom;
            v.id    = 4'($urandom);
            v.rdy   = ($urandom_range(0, 5) == 0);
            v.mdata = {$urandom, $urandom, $urandom, $urandom};
            v.lru   = 2'($urandom);
            apply(v, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
